// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory controller.
// Optional build macro: IMEM_PARITY_EN (per-word even parity).
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Lanes per instruction word at the default 32-bit width.
  localparam int BYTES_PER_WORD = 4;

  function automatic int bytes_per_word(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/imem_word_asm.sv
// Byte-to-word assembler for the program-load port.
// Bytes land little-endian in lane byte_cnt. word_done_o is a combinational
// strobe so the array write happens on the edge that accepts the completing
// byte. Lanes are cleared after every word, so a short final word comes out
// zero-filled in its unreceived lanes.
module imem_word_asm
  import imem_pkg::*;
#(
  parameter int DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear_i,
  input  logic                 byte_valid_i,
  input  logic [7:0]           byte_i,
  input  logic                 last_i,
  output logic [DataWidth-1:0] word_o,
  output logic                 word_done_o
);

  localparam int Bpw  = bytes_per_word(DataWidth);
  localparam int CntW = (Bpw > 1) ? $clog2(Bpw) : 1;

  logic [CntW-1:0]      byte_cnt_q;
  logic [DataWidth-1:0] lanes_q;

  // Merge the incoming byte into its lane and flag word completion.
  always_comb begin
    word_o = lanes_q;
    for (int i = 0; i < Bpw; i++) begin
      if (CntW'(i) == byte_cnt_q) word_o[8*i +: 8] = byte_i;
    end
    word_done_o = byte_valid_i && (last_i || (byte_cnt_q == CntW'(Bpw - 1)));
  end

  // Lane register and byte counter; restart or completion empties the lanes.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      byte_cnt_q <= '0;
      lanes_q    <= '0;
    end else if (byte_valid_i) begin
      if (word_done_o) begin
        byte_cnt_q <= '0;
        lanes_q    <= '0;
      end else begin
        byte_cnt_q <= byte_cnt_q + 1'b1;
        lanes_q    <= word_o;
      end
    end
  end

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory with a registered fetch port and a byte-serial
// program-load port. Fetch is blocked while a load is in progress.
// Optional build macro: IMEM_PARITY_EN stores one even-parity bit per word
// and reports a mismatch on fetch_err.
module instr_mem_ctrl
  import imem_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int Addr      = 8,
  parameter int Depth     = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ld_start,
  input  logic                 ld_valid,
  input  logic [7:0]           ld_byte,
  input  logic                 ld_last,
  output logic                 ld_ready,
  output logic                 ld_busy,
  output logic                 ld_ovf,
  input  logic                 fetch_req,
  input  logic [Addr+1:0]      fetch_addr,
  output logic                 fetch_ready,
  output logic                 fetch_valid,
  output logic [DataWidth-1:0] fetch_data,
  output logic                 fetch_err
);

  state_e               state_q;
  logic [Addr-1:0]      wr_ptr_q;
  logic                 full_q;
  logic                 ld_ovf_q;
  logic                 fetch_valid_q;
  logic [DataWidth-1:0] fetch_data_q;
  logic                 fetch_err_q;
  logic [DataWidth-1:0] mem_q [Depth];

  logic                 asm_feed;
  logic [DataWidth-1:0] asm_word;
  logic                 asm_done;
  logic [Addr-1:0]      fetch_idx;
  logic [DataWidth-1:0] rd_word;
  logic                 par_err;

  assign ld_busy     = (state_q == LOAD);
  assign ld_ready    = ld_busy;
  assign ld_ovf      = ld_ovf_q;
  // Held low during the reset cycle itself, not just after it.
  assign fetch_ready = !reset && !ld_busy;
  assign fetch_valid = fetch_valid_q;
  assign fetch_data  = fetch_data_q;
  assign fetch_err   = fetch_err_q;

  // A restart in the same cycle wins over the byte; a full array discards bytes.
  assign asm_feed  = ld_busy && ld_valid && !ld_start && !full_q;
  assign fetch_idx = fetch_addr[Addr+1:2];
  assign rd_word   = mem_q[fetch_idx];

  imem_word_asm #(.DataWidth(DataWidth)) u_asm (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (ld_start),
    .byte_valid_i(asm_feed),
    .byte_i      (ld_byte),
    .last_i      (ld_last),
    .word_o      (asm_word),
    .word_done_o (asm_done)
  );

  // Load sequencing: state, write pointer, full marker and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      full_q   <= 1'b0;
      ld_ovf_q <= 1'b0;
    end else if (ld_start) begin
      state_q  <= LOAD;
      wr_ptr_q <= '0;
      full_q   <= 1'b0;
      ld_ovf_q <= 1'b0;
    end else if (state_q == LOAD && ld_valid) begin
      if (full_q) ld_ovf_q <= 1'b1;
      if (asm_done) begin
        if (&wr_ptr_q) full_q <= 1'b1;
        else           wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (ld_last) state_q <= RUN;
    end
  end

  // Array write on the edge that accepts the completing byte; never reset.
  always_ff @(posedge clk) begin
    if (!reset && asm_done) mem_q[wr_ptr_q] <= asm_word;
  end

`ifdef IMEM_PARITY_EN
  logic par_q [Depth];

  // Even parity stored alongside each written word.
  always_ff @(posedge clk) begin
    if (!reset && asm_done) par_q[wr_ptr_q] <= ^asm_word;
  end

  assign par_err = ^{rd_word, par_q[fetch_idx]};
`else
  assign par_err = 1'b0;
`endif

  // Registered fetch response: one-cycle valid pulse, data held between responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= '0;
      fetch_err_q   <= 1'b0;
    end else if (fetch_req && fetch_ready) begin
      fetch_valid_q <= 1'b1;
      if (|fetch_addr[1:0]) begin
        fetch_data_q <= '0;
        fetch_err_q  <= 1'b1;
      end else begin
        fetch_data_q <= rd_word;
        fetch_err_q  <= par_err;
      end
    end else begin
      fetch_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Directed bench for instr_mem_ctrl at the default 32-bit / 256-word size.
module tb_instr_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_start, ld_valid, ld_last;
  logic [7:0]  ld_byte;
  logic        ld_ready, ld_busy, ld_ovf;
  logic        fetch_req;
  logic [9:0]  fetch_addr;
  logic        fetch_ready, fetch_valid, fetch_err;
  logic [31:0] fetch_data;

  int total  = 0;
  int passed = 0;

  instr_mem_ctrl #(.DataWidth(32), .Addr(8), .Depth(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .ld_start   (ld_start),
    .ld_valid   (ld_valid),
    .ld_byte    (ld_byte),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .ld_busy    (ld_busy),
    .ld_ovf     (ld_ovf),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid),
    .fetch_data (fetch_data),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic start_load();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic fetch(input logic [9:0] a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    tick();
    fetch_req  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    ld_byte = 8'h00; fetch_req = 1'b0; fetch_addr = '0;

    tick();
    check("rst_fetch_ready", fetch_ready, 0);
    check("rst_ld_ready",    ld_ready,    0);
    check("rst_ld_busy",     ld_busy,     0);
    check("rst_ld_ovf",      ld_ovf,      0);
    check("rst_fetch_valid", fetch_valid, 0);
    check("rst_fetch_data",  fetch_data,  0);
    check("rst_fetch_err",   fetch_err,   0);
    reset = 1'b0;
    #1;
    check("idle_fetch_ready", fetch_ready, 1);

    fetch(10'h000);
    check("f0_valid", fetch_valid, 1);
    check("f0_err",   fetch_err,   0);
    check("f0_ovf",   ld_ovf,      0);
    tick();
    check("f0_pulse", fetch_valid, 0);

    // Two full words, ld_last on a word boundary.
    start_load();
    check("ldA_busy",        ld_busy,     1);
    check("ldA_ready",       ld_ready,    1);
    check("ldA_fetch_ready", fetch_ready, 0);
    send(8'h13, 0); send(8'h05, 0); send(8'hA0, 0); send(8'h00, 0);
    send(8'h93, 0); send(8'h05, 0); send(8'h10, 0); send(8'h00, 1);
    check("ldA_busy_done", ld_busy,     0);
    check("ldA_fready",    fetch_ready, 1);
    fetch_req = 1'b1; fetch_addr = 10'h004;
    tick();
    check("ldA_w1", fetch_data, 32'h00100593);
    check("ldA_v1", fetch_valid, 1);
    fetch_addr = 10'h000;
    tick();
    fetch_req = 1'b0;
    check("ldA_w0", fetch_data, 32'h00A00513);
    check("ldA_v0", fetch_valid, 1);
    tick();
    check("ldA_pulse", fetch_valid, 0);
    check("ldA_hold",  fetch_data,  32'h00A00513);

    // Partial final word is zero-filled.
    start_load();
    send(8'hEF, 0); send(8'hBE, 0); send(8'hAD, 0); send(8'hDE, 0); send(8'h11, 1);
    check("ldB_busy", ld_busy, 0);
    fetch(10'h000);
    check("ldB_w0", fetch_data, 32'hDEADBEEF);
    fetch(10'h004);
    check("ldB_w1", fetch_data, 32'h00000011);

    // ld_last on a full word writes once and does not touch the next word.
    start_load();
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 1);
    fetch(10'h000);
    check("ldC_w0", fetch_data, 32'h04030201);
    fetch(10'h004);
    check("ldC_w1", fetch_data, 32'h00000011);

    fetch(10'h002);
    check("mis_valid", fetch_valid, 1);
    check("mis_err",   fetch_err,   1);
    check("mis_data",  fetch_data,  0);
    fetch(10'h000);
    check("al_err", fetch_err, 0);

    // ld_start and fetch_req together, then a restart mid-word.
    fetch_req = 1'b1; fetch_addr = 10'h004; ld_start = 1'b1;
    tick();
    fetch_req = 1'b0; ld_start = 1'b0;
    check("cmb_valid", fetch_valid, 1);
    check("cmb_data",  fetch_data,  32'h00000011);
    check("cmb_fready", fetch_ready, 0);
    check("cmb_busy",  ld_busy,     1);
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0);
    start_load();
    send(8'h78, 0); send(8'h56, 0); send(8'h34, 0); send(8'h12, 1);
    fetch(10'h000);
    check("rst_ld_w0", fetch_data, 32'h12345678);

    // Overflow: Depth words fill the array, four extra bytes are discarded.
    start_load();
    for (int i = 0; i < 1028; i++) begin
      send((i < 1024) ? (i[7:0] ^ 8'h5A) : 8'hFF, i == 1027);
      if (i == 1023) check("ovf_at_full", ld_ovf, 0);
      if (i == 1026) begin
        check("ovf_set",  ld_ovf,  1);
        check("ovf_busy", ld_busy, 1);
      end
    end
    check("ovf_sticky", ld_ovf,  1);
    check("ovf_run",    ld_busy, 0);
    fetch(10'h000);
    check("ovf_w0",   fetch_data, 32'h59585B5A);
    fetch(10'h3FC);
    check("ovf_w255", fetch_data, 32'hA5A4A7A6);
    start_load();
    check("ovf_clear", ld_ovf,  0);
    check("ovf_busy2", ld_busy, 1);

    // Reset mid-word: pointers clear, next load starts at word 0 lane 0.
    send(8'h99, 0); send(8'h88, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("mr_busy",   ld_busy,     0);
    check("mr_fready", fetch_ready, 1);
    start_load();
    send(8'h44, 0); send(8'h33, 0); send(8'h22, 0); send(8'h11, 1);
    fetch(10'h000);
    check("mr_w0", fetch_data, 32'h11223344);
    fetch(10'h3FC);
    check("mr_w255_kept", fetch_data, 32'hA5A4A7A6);

`ifdef IMEM_PARITY_EN
    dut.par_q[0] = ~dut.par_q[0];
    fetch(10'h000);
    check("par_err",  fetch_err,  1);
    check("par_data", fetch_data, 32'h11223344);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_mem_ctrl.md
# instr_mem_ctrl

Parametrised instruction memory for the RV32I core with a registered fetch port and a byte-serial program-load port. Replaces the hex-file-only instruction store: after reset, a boot source (UART receiver or testbench) streams a program in, and the fetch stage then reads it. Sits between the boot/debug byte source and the IF stage; fetch is blocked while a load is in progress.

## Interface
- DataWidth, 32: instruction word width; multiple of 8.
- Addr, 8: word-index width.
- Depth, 256: words stored; must equal 2**Addr.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- ld_start  in  1  pulse; begin a program load at word 0.
- ld_valid  in  1  ld_byte is valid.
- ld_byte  in  8  program byte, little-endian within each word.
- ld_last  in  1  qualifies the final byte of the program; sampled with ld_valid.
- ld_ready  out  1  block accepts a byte this cycle.
- ld_busy  out  1  high in LOAD state.
- ld_ovf  out  1  sticky; bytes were received beyond Depth words.
- fetch_req  in  1  fetch request.
- fetch_addr  in  Addr+2  byte address (PC).
- fetch_ready  out  1  request accepted this cycle.
- fetch_valid  out  1  fetch_data/fetch_err valid.
- fetch_data  out  DataWidth  instruction word.
- fetch_err  out  1  misaligned fetch, or parity error when parity is enabled.

## Operation
- States: IDLE, LOAD, RUN. Reset -> IDLE. No initial file load; the array is not cleared by reset.
- IDLE: fetch_ready=1. ld_start -> LOAD.
- LOAD: ld_ready=1, fetch_ready=0. Each ld_valid byte goes into lane byte_cnt of the assembly register. When byte_cnt reaches DataWidth/8-1, write mem[wr_ptr], then wr_ptr++ and byte_cnt=0.
- LOAD with ld_last: write the partial word with unreceived lanes zero-filled, then -> RUN. If ld_last lands on a full word, write exactly once.
- Overflow: once wr_ptr has written Depth words, ld_ovf is set, further bytes are accepted and discarded, and wr_ptr does not wrap. ld_ovf clears on ld_start or reset.
- RUN: same as IDLE. ld_start -> LOAD, restarting at wr_ptr=0 and byte_cnt=0.
- ld_start while in LOAD: restart at word 0. Any partial word is discarded.
- Fetch: the request is accepted when fetch_req && fetch_ready. Word index is fetch_addr[Addr+1:2].
- Misaligned fetch (fetch_addr[1:0]!=0): fetch_err=1 and fetch_data=0.

## Timing
- Reset values: ld_ready=0, ld_busy=0, ld_ovf=0, fetch_ready=0 during the reset cycle and 1 afterwards, fetch_valid=0, fetch_data=0, fetch_err=0.
- Fetch latency is 1 cycle, with a registered output. Back-to-back requests give one word per cycle.
- fetch_valid is a single-cycle pulse per accepted request. fetch_data holds its value until the next response.
- ld_start together with fetch_req in the same cycle: the fetch is accepted and answered next cycle, and fetch_ready=0 from the next cycle.
- A memory write occurs on the edge that accepts the completing byte. A fetch of that word issued in a later cycle returns the new data; no same-cycle bypass.
- ld_busy falls on the edge after ld_last is accepted.
- Reset mid-load: -> IDLE, pointers cleared. Words already written are kept.

## Configuration
- IMEM_PARITY_EN defined: one even-parity bit is stored per word, computed on write and checked on fetch. A mismatch sets fetch_err with fetch_valid, and fetch_data still returns the stored word.
- IMEM_PARITY_EN undefined: no parity storage, and fetch_err reports misalignment only.

## Structure
- Shared package imem_pkg: state enum (IDLE, LOAD, RUN) and the BYTES_PER_WORD constant.
- One sub-module, imem_word_asm: byte-to-word assembler with byte_cnt, lane register, zero-fill and word_done strobe. The FSM, array and fetch port stay in the top.

## Test plan
- Reset, then fetch 0x000 -> fetch_valid next cycle, fetch_err=0, ld_ovf=0.
- ld_start; stream bytes 13 05 A0 00 | 93 05 10 00 with ld_last on the 8th -> mem[0]=0x00A00513, mem[1]=0x00100593; fetch 0x004 returns 0x00100593 one cycle later.
- Load 5 bytes EF BE AD DE 11 with ld_last -> mem[1]=0x00000011, state RUN.
- Fetch 0x002 -> fetch_valid=1, fetch_err=1, fetch_data=0.
- Stream Depth*4+4 bytes -> ld_ovf=1; mem[0] unchanged by the excess bytes; ld_start clears ld_ovf.
- Assert reset after 2 bytes of a word -> IDLE; the next load starts at word 0. With IMEM_PARITY_EN, force a flipped array bit -> fetch_err=1.
